// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative 16-bit multiply/divide unit.
// Used by both the iteration datapath and the control/top level.
package muldiv_pkg;

   localparam int WIDTH = 16;
   localparam int ITER  = 16;
   localparam int CNT_W = 5;

   localparam logic [CNT_W-1:0] ITER_CNT = CNT_W'(ITER);

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   // Quotient reported when the divisor is zero
   localparam logic [WIDTH-1:0] DBZ_QUOTIENT = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of either shift-add multiply or restoring divide.
// The accumulator pair is {accHi, accLo}; operand is the multiplicand or divisor.
module muldiv_step
   import muldiv_pkg::*;
(
   input  logic             op,
   input  logic [WIDTH-1:0] accHi,
   input  logic [WIDTH-1:0] accLo,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] nextHi,
   output logic [WIDTH-1:0] nextLo
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_shiftRem;
   logic [WIDTH:0] w_trial;

   always_comb begin
      nextHi     = accHi;
      nextLo     = accLo;
      w_sum      = '0;
      w_shiftRem = '0;
      w_trial    = '0;
      if (op == OP_MUL) begin
         // Carry out of the upper-half add shifts back in as the new MSB
         w_sum            = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
         {nextHi, nextLo} = {w_sum, accLo[WIDTH-1:1]};
      end else begin
         // Remainder after the shift is 17 bits wide; bit WIDTH of the trial is its sign
         w_shiftRem = {accHi, accLo[WIDTH-1]};
         w_trial    = w_shiftRem - {1'b0, operand};
         if (!w_trial[WIDTH]) begin
            nextHi = w_trial[WIDTH-1:0];
            nextLo = {accLo[WIDTH-2:0], 1'b1};
         end else begin
            nextHi = w_shiftRem[WIDTH-1:0];
            nextLo = {accLo[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned 16x16 multiply / 16/16 divide with a 3-state control FSM.
// Results are copied to the output registers only on the final iteration.
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] operandA,
   input  logic [WIDTH-1:0] operandB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] resultLo,
   output logic [WIDTH-1:0] resultHi,
   output logic             divByZero
);

   state_t           r_state;
   logic             r_op;
   logic [WIDTH-1:0] r_operand;
   logic [WIDTH-1:0] r_accHi;
   logic [WIDTH-1:0] r_accLo;
   logic [CNT_W-1:0] r_count;

   logic [WIDTH-1:0] w_nextHi;
   logic [WIDTH-1:0] w_nextLo;

   muldiv_step u_step (
      .op      (r_op),
      .accHi   (r_accHi),
      .accLo   (r_accLo),
      .operand (r_operand),
      .nextHi  (w_nextHi),
      .nextLo  (w_nextLo)
   );

   // IDLE and DONE both accept a new start, which gives back-to-back issue
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_op      <= OP_MUL;
         r_operand <= '0;
         r_accHi   <= '0;
         r_accLo   <= '0;
         r_count   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         resultLo  <= '0;
         resultHi  <= '0;
         divByZero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_op      <= op;
                  r_count   <= ITER_CNT;
                  r_accHi   <= '0;
                  divByZero <= 1'b0;
                  if (op == OP_DIV && operandB == '0) begin
                     resultLo  <= DBZ_QUOTIENT;
                     resultHi  <= operandA;
                     divByZero <= 1'b1;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     r_state   <= ST_DONE;
                  end else begin
                     // Multiply keeps the multiplier in the low half; divide keeps the dividend
                     r_operand <= (op == OP_MUL) ? operandA : operandB;
                     r_accLo   <= (op == OP_MUL) ? operandB : operandA;
                     busy      <= 1'b1;
                     r_state   <= ST_RUN;
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               r_accHi <= w_nextHi;
               r_accLo <= w_nextLo;
               r_count <= r_count - CNT_W'(1);
               if (r_count == CNT_W'(1)) begin
                  resultHi <= w_nextHi;
                  resultLo <= w_nextLo;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  r_state  <= ST_DONE;
               end
            end
            default: begin
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, divide-by-zero,
// start-while-busy, reset mid-operation and back-to-back issue.
module tb_muldiv_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        op;
   logic [15:0] operandA;
   logic [15:0] operandB;
   logic        busy;
   logic        done;
   logic [15:0] resultLo;
   logic [15:0] resultHi;
   logic        divByZero;

   int checks   = 0;
   int failures = 0;

   int   cycles;
   int   busyCnt;
   logic firstBusy;
   logic firstDbz;
   int   doneSeen;

   muldiv_unit dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .operandA  (operandA),
      .operandB  (operandB),
      .busy      (busy),
      .done      (done),
      .resultLo  (resultLo),
      .resultHi  (resultHi),
      .divByZero (divByZero)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Launches one operation from a negedge and runs until done (or timeout);
   // midCycle > 0 pulses a second start with new operands during RUN.
   task automatic applyStimulus(input logic opIn, input logic [15:0] a, input logic [15:0] b, input int midCycle);
      start    = 1'b1;
      op       = opIn;
      operandA = a;
      operandB = b;
      @(negedge clock);
      start     = 1'b0;
      operandA  = 16'hDEAD;
      operandB  = 16'hBEEF;
      cycles    = 1;
      busyCnt   = 0;
      firstBusy = busy;
      firstDbz  = divByZero;
      while (!done && cycles < 40) begin
         if (busy) busyCnt++;
         if (cycles == midCycle) begin
            start    = 1'b1;
            op       = 1'b1;
            operandA = 16'h0009;
            operandB = 16'h0003;
         end else begin
            start = 1'b0;
         end
         @(negedge clock);
         cycles++;
      end
      start = 1'b0;
      checkOutput("doneBeforeTimeout", {31'd0, done}, 32'd1);
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      op       = 1'b0;
      operandA = '0;
      operandB = '0;
      repeat (3) @(negedge clock);
      checkOutput("rstBusy", {31'd0, busy}, 32'd0);
      checkOutput("rstDone", {31'd0, done}, 32'd0);
      checkOutput("rstLo", {16'd0, resultLo}, 32'd0);
      checkOutput("rstHi", {16'd0, resultHi}, 32'd0);
      checkOutput("rstDbz", {31'd0, divByZero}, 32'd0);
      reset = 1'b0;
      @(negedge clock);

      $display("[TB] multiply 0x1234 * 0x0010");
      applyStimulus(1'b0, 16'h1234, 16'h0010, 0);
      checkOutput("mul1Latency", cycles, 17);
      checkOutput("mul1BusyCycles", busyCnt, 16);
      checkOutput("mul1FirstBusy", {31'd0, firstBusy}, 32'd1);
      checkOutput("mul1BusyAtDone", {31'd0, busy}, 32'd0);
      checkOutput("mul1Hi", {16'd0, resultHi}, 32'h0001);
      checkOutput("mul1Lo", {16'd0, resultLo}, 32'h2340);
      @(negedge clock);
      checkOutput("mul1DonePulse", {31'd0, done}, 32'd0);
      checkOutput("mul1HoldLo", {16'd0, resultLo}, 32'h2340);

      $display("[TB] multiply maximum");
      applyStimulus(1'b0, 16'hFFFF, 16'hFFFF, 0);
      checkOutput("mulMaxHi", {16'd0, resultHi}, 32'hFFFE);
      checkOutput("mulMaxLo", {16'd0, resultLo}, 32'h0001);
      @(negedge clock);

      $display("[TB] divide 100 / 7");
      applyStimulus(1'b1, 16'd100, 16'd7, 0);
      checkOutput("div1Latency", cycles, 17);
      checkOutput("div1Quo", {16'd0, resultLo}, 32'd14);
      checkOutput("div1Rem", {16'd0, resultHi}, 32'd2);
      checkOutput("div1Dbz", {31'd0, divByZero}, 32'd0);
      @(negedge clock);

      $display("[TB] divide by zero");
      applyStimulus(1'b1, 16'h5555, 16'h0000, 0);
      checkOutput("dbzLatency", cycles, 1);
      checkOutput("dbzBusy", busyCnt, 0);
      checkOutput("dbzFirstBusy", {31'd0, firstBusy}, 32'd0);
      checkOutput("dbzLo", {16'd0, resultLo}, 32'hFFFF);
      checkOutput("dbzHi", {16'd0, resultHi}, 32'h5555);
      checkOutput("dbzFlag", {31'd0, divByZero}, 32'd1);
      @(negedge clock);
      checkOutput("dbzHoldFlag", {31'd0, divByZero}, 32'd1);

      $display("[TB] valid divide clears divByZero");
      applyStimulus(1'b1, 16'h5555, 16'h0003, 0);
      checkOutput("clrFirstDbz", {31'd0, firstDbz}, 32'd0);
      checkOutput("clrQuo", {16'd0, resultLo}, 32'h1C71);
      checkOutput("clrRem", {16'd0, resultHi}, 32'h0002);
      checkOutput("clrDbz", {31'd0, divByZero}, 32'd0);
      @(negedge clock);

      $display("[TB] start while busy is ignored");
      applyStimulus(1'b0, 16'h00FF, 16'h0101, 5);
      checkOutput("busyStartLatency", cycles, 17);
      checkOutput("busyStartHi", {16'd0, resultHi}, 32'h0000);
      checkOutput("busyStartLo", {16'd0, resultLo}, 32'hFFFF);
      @(negedge clock);
      checkOutput("busyStartNoRerun", {31'd0, busy}, 32'd0);
      @(negedge clock);

      $display("[TB] reset mid-operation");
      start    = 1'b1;
      op       = 1'b0;
      operandA = 16'h0003;
      operandB = 16'h0005;
      @(negedge clock);
      start = 1'b0;
      repeat (7) @(negedge clock);
      checkOutput("preRstBusy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
      checkOutput("midRstDone", {31'd0, done}, 32'd0);
      checkOutput("midRstLo", {16'd0, resultLo}, 32'd0);
      checkOutput("midRstHi", {16'd0, resultHi}, 32'd0);
      checkOutput("midRstDbz", {31'd0, divByZero}, 32'd0);
      doneSeen = 0;
      repeat (20) begin
         @(negedge clock);
         if (done || busy) doneSeen++;
      end
      checkOutput("midRstStaysIdle", doneSeen, 0);

      $display("[TB] back-to-back");
      applyStimulus(1'b0, 16'd3, 16'd5, 0);
      checkOutput("b2bFirstLo", {16'd0, resultLo}, 32'd15);
      checkOutput("b2bFirstHi", {16'd0, resultHi}, 32'd0);
      applyStimulus(1'b1, 16'd1000, 16'd10, 0);
      checkOutput("b2bSecondFirstBusy", {31'd0, firstBusy}, 32'd1);
      checkOutput("b2bSecondLatency", cycles, 17);
      checkOutput("b2bSecondQuo", {16'd0, resultLo}, 32'd100);
      checkOutput("b2bSecondRem", {16'd0, resultHi}, 32'd0);
      @(negedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 16-bit unsigned multiply/divide unit, downstream of the 8×16 register file. It consumes the two registered read-port operands (`readData1`, `readData2`), runs a 16-iteration shift-add multiply or restoring divide, and presents a 32-bit result as two 16-bit halves. Those halves go back to the register file's write port through the `writeFile` mux. The control FSM launches it with a one-cycle `start` and stalls on `busy` until `done`.

## Interface
- `WIDTH`, 16: operand width; result is 2×WIDTH split into hi/lo halves.
- `ITER`, 16: iteration count; must equal `WIDTH`.

Ports:
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle launch pulse; sampled in IDLE and DONE only.
- `op`  in  1  0 = multiply, 1 = divide; sampled with `start`.
- `operandA`  in  16  multiplicand / dividend (from `readData1`).
- `operandB`  in  16  multiplier / divisor (from `readData2`).
- `busy`  out  1  high while an operation is in RUN.
- `done`  out  1  one-cycle pulse; results valid from this cycle.
- `resultLo`  out  16  product[15:0] / quotient.
- `resultHi`  out  16  product[31:16] / remainder.
- `divByZero`  out  1  set on a divide with `operandB` = 0; cleared on next accepted `start`.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - `start` = 1 latches `op`, `operandA` and `operandB`, loads the counter with `ITER`, and clears `divByZero`.
  - Next state is RUN, except for a divide with B = 0, which goes straight to DONE.
- **RUN:**
  - One iteration per cycle; counter decrements each cycle.
  - At counter = 1 the final iteration completes and the FSM goes to DONE.
  - `start` is ignored (no latch, no effect).
- **DONE:**
  - `done` = 1 for exactly this cycle; result registers are already updated.
  - With `start` = 1, a new operation is accepted exactly as in IDLE (back-to-back); otherwise the FSM returns to IDLE.
- **Multiply:**
  - Unsigned shift-add on a 32-bit accumulator.
  - Each iteration: if the multiplier LSB = 1, add the multiplicand to the upper half, then shift the {carry, acc} pair right by 1.
  - Full 32-bit product; no overflow flag.
- **Divide:**
  - Unsigned restoring division.
  - Each iteration: shift {rem, quo} left by 1, then trial-subtract the divisor from rem.
  - If the trial result is non-negative, commit it and set quo LSB = 1; otherwise restore.
- **Divide by zero:**
  - `resultLo` = 0xFFFF, `resultHi` = dividend, `divByZero` = 1.
  - No RUN phase.
- **Result hold:** `resultLo`, `resultHi` and `divByZero` hold their values until the next accepted `start`. Intermediate accumulator values are never visible on the result ports.
- **Reset:** aborts any operation at any state; the next state is IDLE.

## Timing
- **Reset values:** `busy` = 0, `done` = 0, `resultLo` = 0, `resultHi` = 0, `divByZero` = 0, state = IDLE.
- **Normal latency:** with `start` sampled at edge 0, `busy` is high from edge 0 through edge 16. `done` is high after edge 16 until edge 17, i.e. 17 cycles start-to-done.
- **Divide-by-zero latency:** `done` is high the cycle after the `start` edge (1 cycle); `busy` never rises.
- **Back-to-back:** `start` in DONE gives `busy` = 1 the next cycle, with no idle gap.
- **Input stability:** operands need only be stable in the `start` cycle. The register file's 1-cycle read latency means the FSM asserts `start` one cycle after presenting the register addresses.
- **Outputs:** all outputs are registered; no combinational path from inputs to outputs.

## Structure
- **Shared package `muldiv_pkg`:**
  - state enum (IDLE/RUN/DONE)
  - `OP_MUL`/`OP_DIV` constants
  - `WIDTH`, `ITER`
  - div-by-zero quotient constant 0xFFFF
- **Sub-module `muldiv_step`:** combinational single iteration. Inputs are `op`, the accumulator pair and the operand; outputs are the next accumulator pair. The top level holds the FSM, counter and registers.

## Test plan
- **Multiply:** `op` = 0, A = 0x1234, B = 0x0010 → after 17 cycles `done`, hi = 0x0001, lo = 0x2340; `busy` high for exactly 16 cycles.
- **Multiply maximum:** `op` = 0, A = 0xFFFF, B = 0xFFFF → hi = 0xFFFE, lo = 0x0001.
- **Divide:** `op` = 1, A = 100, B = 7 → lo = 14, hi = 2, `divByZero` = 0.
- **Divide by zero:** `op` = 1, A = 0x5555, B = 0 → `done` 1 cycle later, lo = 0xFFFF, hi = 0x5555, `divByZero` = 1. A following valid `start` clears `divByZero`.
- **Start while busy:** `start` pulsed mid-RUN with new operands → ignored; the original result is correct.
- **Reset mid-operation:** `reset` at iteration 8 → all outputs 0 and IDLE next cycle.
- **Back-to-back:** `start` asserted in the DONE cycle → second op begins immediately and both results are correct.
